// File: rtl/point_parser.sv
// ASCII "x,y,z\n" line parser feeding parsed points to the day-8 solver.
// Stops after NUM_POINTS points; malformed lines set a sticky error and are dropped.
module point_parser #(
  parameter int unsigned NUM_POINTS = 3,
  parameter int unsigned DIM_W      = 10
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [7:0]                        in_byte,
  input  logic                              in_vld,
  output logic                              in_rdy,
  output logic [DIM_W-1:0]                  xloc,
  output logic [DIM_W-1:0]                  yloc,
  output logic [DIM_W-1:0]                  zloc,
  output logic                              locs_vld,
  input  logic                              locs_rdy,
  output logic [$clog2(NUM_POINTS+1)-1:0]   pt_cnt,
  output logic                              done,
  output logic                              parse_err
);

  localparam int unsigned CNT_W = $clog2(NUM_POINTS + 1);
  localparam int unsigned ACC_W = DIM_W + 4;

  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;

  typedef enum logic [2:0] {FX, FY, FZ, HOLD, SKIP, DONE} state_t;

  state_t             state_q, state_d;
  logic [DIM_W-1:0]   acc_x_q, acc_y_q, acc_z_q;
  logic [DIM_W-1:0]   acc_x_d, acc_y_d, acc_z_d;
  logic               seen_q, seen_d;
  logic [DIM_W-1:0]   xloc_d, yloc_d, zloc_d;
  logic               locs_vld_d, done_d, parse_err_d;
  logic [CNT_W-1:0]   pt_cnt_d;

  logic [DIM_W-1:0]   acc_cur;
  logic [ACC_W-1:0]   acc_nxt;
  logic               acc_ovf;
  logic               is_digit;
  logic               clr;

  // Ready is a pure decode of the state register.
  assign in_rdy = (state_q == FX) || (state_q == FY) || (state_q == FZ) || (state_q == SKIP);

  always_comb begin
    state_d     = state_q;
    acc_x_d     = acc_x_q;
    acc_y_d     = acc_y_q;
    acc_z_d     = acc_z_q;
    seen_d      = seen_q;
    xloc_d      = xloc;
    yloc_d      = yloc;
    zloc_d      = zloc;
    locs_vld_d  = locs_vld;
    pt_cnt_d    = pt_cnt;
    done_d      = done;
    parse_err_d = parse_err;
    clr         = 1'b0;

    acc_cur  = (state_q == FY) ? acc_y_q : (state_q == FZ) ? acc_z_q : acc_x_q;
    is_digit = (in_byte >= CH_0) && (in_byte <= CH_9);
    // Widened by 4 bits so acc*10+9 can never wrap before the range check.
    acc_nxt  = ACC_W'(acc_cur) * ACC_W'(10) + ACC_W'(in_byte[3:0]);
    acc_ovf  = |acc_nxt[ACC_W-1:DIM_W];

    unique case (state_q)
      FX, FY, FZ: begin
        if (in_vld) begin
          if (is_digit) begin
            if (acc_ovf) begin
              parse_err_d = 1'b1;
              state_d     = SKIP;
            end else begin
              seen_d = 1'b1;
              case (state_q)
                FY:      acc_y_d = acc_nxt[DIM_W-1:0];
                FZ:      acc_z_d = acc_nxt[DIM_W-1:0];
                default: acc_x_d = acc_nxt[DIM_W-1:0];
              endcase
            end
          end else if ((in_byte == CH_COMMA) && (state_q != FZ) && seen_q) begin
            seen_d  = 1'b0;
            state_d = (state_q == FX) ? FY : FZ;
          end else if (in_byte == CH_LF) begin
            if ((state_q == FZ) && seen_q) begin
              xloc_d     = acc_x_q;
              yloc_d     = acc_y_q;
              zloc_d     = acc_z_q;
              locs_vld_d = 1'b1;
              state_d    = HOLD;
            end else if (!((state_q == FX) && !seen_q)) begin
              // Truncated line: the newline already ends it, so restart directly.
              parse_err_d = 1'b1;
              clr         = 1'b1;
              state_d     = FX;
            end
          end else if ((in_byte == CH_CR) || (in_byte == CH_SP)) begin
            state_d = state_q;
          end else begin
            parse_err_d = 1'b1;
            state_d     = SKIP;
          end
        end
      end
      SKIP: begin
        if (in_vld && (in_byte == CH_LF)) begin
          clr     = 1'b1;
          state_d = FX;
        end
      end
      HOLD: begin
        if (locs_rdy) begin
          locs_vld_d = 1'b0;
          pt_cnt_d   = pt_cnt + CNT_W'(1);
          if (pt_cnt_d == CNT_W'(NUM_POINTS)) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            clr     = 1'b1;
            state_d = FX;
          end
        end
      end
      DONE: begin
        locs_vld_d = 1'b0;
        done_d     = 1'b1;
      end
      default: state_d = FX;
    endcase

    if (clr) begin
      acc_x_d = '0;
      acc_y_d = '0;
      acc_z_d = '0;
      seen_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FX;
      acc_x_q   <= '0;
      acc_y_q   <= '0;
      acc_z_q   <= '0;
      seen_q    <= 1'b0;
      xloc      <= '0;
      yloc      <= '0;
      zloc      <= '0;
      locs_vld  <= 1'b0;
      pt_cnt    <= '0;
      done      <= 1'b0;
      parse_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_x_q   <= acc_x_d;
      acc_y_q   <= acc_y_d;
      acc_z_q   <= acc_z_d;
      seen_q    <= seen_d;
      xloc      <= xloc_d;
      yloc      <= yloc_d;
      zloc      <= zloc_d;
      locs_vld  <= locs_vld_d;
      pt_cnt    <= pt_cnt_d;
      done      <= done_d;
      parse_err <= parse_err_d;
    end
  end

endmodule

// File: tb/tb_point_parser.sv
// Directed bench for point_parser with NUM_POINTS=3, DIM_W=10.
module tb_point_parser;

  localparam int unsigned NP = 3;
  localparam int unsigned DW = 10;
  localparam int unsigned CW = $clog2(NP + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    in_byte;
  logic          in_vld;
  logic          in_rdy;
  logic [DW-1:0] xloc, yloc, zloc;
  logic          locs_vld;
  logic          locs_rdy;
  logic [CW-1:0] pt_cnt;
  logic          done;
  logic          parse_err;

  int tests = 0;
  int fails = 0;

  logic [3*DW-1:0] pts[$];
  int              vld_cycles;

  point_parser #(.NUM_POINTS(NP), .DIM_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .in_vld(in_vld), .in_rdy(in_rdy),
    .xloc(xloc), .yloc(yloc), .zloc(zloc), .locs_vld(locs_vld), .locs_rdy(locs_rdy),
    .pt_cnt(pt_cnt), .done(done), .parse_err(parse_err)
  );

  always #5 clk = ~clk;

  // Record every handed-off point and how many cycles locs_vld was high.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pts.delete();
      vld_cycles = 0;
    end else begin
      if (locs_vld) vld_cycles++;
      if (locs_vld && locs_rdy) pts.push_back({xloc, yloc, zloc});
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_pt(input string tag, input int idx, input int x, input int y, input int z);
    logic [3*DW-1:0] p;
    p = (idx < pts.size()) ? pts[idx] : '1;
    check({tag, "_x"}, 32'(p[3*DW-1:2*DW]), 32'(x));
    check({tag, "_y"}, 32'(p[2*DW-1:DW]), 32'(y));
    check({tag, "_z"}, 32'(p[DW-1:0]), 32'(z));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    in_vld = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    in_byte = b;
    in_vld  = 1'b1;
    while (!in_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_rdy) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: observed in_rdy=0 expected 1 within 50 cycles");
      in_vld = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_vld = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_vld   = 1'b0;
    in_byte  = 8'h00;
    locs_rdy = 1'b1;

    // Reset state
    do_reset();
    check("rst_in_rdy", 32'(in_rdy), 32'd1);
    check("rst_locs_vld", 32'(locs_vld), 32'd0);
    check("rst_pt_cnt", 32'(pt_cnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(parse_err), 32'd0);
    check("rst_xloc", 32'(xloc), 32'd0);

    // 1: single point, one-cycle latency after the newline
    send_str("162,817,812");
    send_byte(8'h0A);
    check("t1_vld_latency", 32'(locs_vld), 32'd1);
    check("t1_in_rdy_hold", 32'(in_rdy), 32'd0);
    idle(3);
    check("t1_npts", 32'(pts.size()), 32'd1);
    check_pt("t1_pt", 0, 162, 817, 812);
    check("t1_vld_cycles", 32'(vld_cycles), 32'd1);
    check("t1_pt_cnt", 32'(pt_cnt), 32'd1);
    check("t1_err", 32'(parse_err), 32'd0);

    // 2: back-pressure holds the point and blocks input
    do_reset();
    locs_rdy = 1'b0;
    send_str("7,8,9\n");
    in_byte = "4";
    in_vld  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_vld", 32'(locs_vld), 32'd1);
      check("t2_x", 32'(xloc), 32'd7);
      check("t2_z", 32'(zloc), 32'd9);
      check("t2_in_rdy", 32'(in_rdy), 32'd0);
    end
    locs_rdy = 1'b1;
    @(posedge clk);
    #1;
    check("t2_vld_drop", 32'(locs_vld), 32'd0);
    check("t2_pt_cnt", 32'(pt_cnt), 32'd1);
    @(negedge clk);
    check("t2_in_rdy_fx", 32'(in_rdy), 32'd1);
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    send_str(",4,4\n");
    idle(3);
    check("t2_npts", 32'(pts.size()), 32'd2);
    check_pt("t2_pt0", 0, 7, 8, 9);
    check_pt("t2_pt1", 1, 4, 4, 4);
    check("t2_pt_cnt2", 32'(pt_cnt), 32'd2);

    // 3: short line is an error and dropped
    do_reset();
    send_str("1,2\n5,6,7\n");
    idle(3);
    check("t3_err", 32'(parse_err), 32'd1);
    check("t3_npts", 32'(pts.size()), 32'd1);
    check_pt("t3_pt", 0, 5, 6, 7);
    check("t3_pt_cnt", 32'(pt_cnt), 32'd1);

    // 4: blank lines, CR and spaces are ignored
    do_reset();
    send_str("\r\n \n3,4,5\r\n");
    idle(3);
    check("t4_err", 32'(parse_err), 32'd0);
    check("t4_npts", 32'(pts.size()), 32'd1);
    check_pt("t4_pt", 0, 3, 4, 5);

    // 5: 1023 fits, 1024 overflows
    do_reset();
    send_str("1023,0,1\n");
    idle(3);
    check("t5_no_err_max", 32'(parse_err), 32'd0);
    send_str("1024,0,0\n9,9,9\n");
    idle(3);
    check("t5_err", 32'(parse_err), 32'd1);
    check("t5_npts", 32'(pts.size()), 32'd2);
    check_pt("t5_pt0", 0, 1023, 0, 1);
    check_pt("t5_pt1", 1, 9, 9, 9);

    // 6: stop after NUM_POINTS, then mid-line reset
    do_reset();
    send_str("1,1,1\n2,2,2\n3,3,3\n");
    idle(3);
    check("t6_done", 32'(done), 32'd1);
    check("t6_pt_cnt", 32'(pt_cnt), 32'd3);
    check("t6_in_rdy", 32'(in_rdy), 32'd0);
    check("t6_vld", 32'(locs_vld), 32'd0);
    in_byte = "4";
    in_vld  = 1'b1;
    idle(5);
    in_vld = 1'b0;
    check("t6_npts", 32'(pts.size()), 32'd3);
    check_pt("t6_pt2", 2, 3, 3, 3);
    check("t6_still_done", 32'(done), 32'd1);

    do_reset();
    send_str("5,6,7\n5,6");
    @(negedge clk);
    check("t6_pre_rst_cnt", 32'(pt_cnt), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_cnt", 32'(pt_cnt), 32'd0);
    check("t6_rst_x", 32'(xloc), 32'd0);
    check("t6_rst_vld", 32'(locs_vld), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_rel_in_rdy", 32'(in_rdy), 32'd1);
    check("t6_rel_done", 32'(done), 32'd0);
    send_str("8,8,8\n");
    idle(3);
    check("t6_after_npts", 32'(pts.size()), 32'd1);
    check_pt("t6_after_pt", 0, 8, 8, 8);
    check("t6_after_err", 32'(parse_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
